// File: rtl/count_display_driver_pkg.sv
// Shared types, widths and the seven-segment decode for the count display path.
// Leading-zero blanking in the top level is enabled by LEADING_ZERO_BLANK_EN.
package count_display_pkg;

    localparam int unsigned VALUE_W    = 8;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned SHIFT_W    = BCD_W + VALUE_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned NUM_SHIFTS = 8;
    localparam int unsigned BIT_CNT_W  = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    typedef logic [1:0] digit_idx_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] hundreds;
        logic [NIBBLE_W-1:0] tens;
        logic [NIBBLE_W-1:0] ones;
    } bcd_t;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render blank.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIBBLE_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [NIBBLE_W-1:0] dabble_adj(input logic [NIBBLE_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/count_display_driver_bcd_converter.sv
// Free-running sequential double-dabble: 8-bit binary to 3-digit BCD every 10 clocks.
// bcd only changes in LATCH, so it never shows a partial conversion.
module bcd_converter
    import count_display_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    output logic [BCD_W-1:0]   bcd,
    output logic               busy
);

    conv_state_t            r_state;
    conv_state_t            w_state_next;
    logic [SHIFT_W-1:0]     r_shift;
    logic [SHIFT_W-1:0]     w_shift_next;
    logic [SHIFT_W-1:0]     w_shift_adj;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic [BCD_W-1:0]       r_bcd;
    logic [BCD_W-1:0]       w_bcd_next;
    logic                   r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bcd     <= w_bcd_next;
            r_busy    <= (w_state_next != IDLE);
        end
    end

    // Next-state and datapath for capture / shift / latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_bcd_next     = r_bcd;
        w_shift_adj    = {dabble_adj(r_shift[19:16]),
                          dabble_adj(r_shift[15:12]),
                          dabble_adj(r_shift[11:8]),
                          r_shift[7:0]};
        case (r_state)
            IDLE: begin
                w_shift_next   = {12'h000, value};
                w_bit_cnt_next = '0;
                w_state_next   = SHIFT;
            end
            SHIFT: begin
                w_shift_next   = w_shift_adj << 1;
                w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                if (r_bit_cnt == BIT_CNT_W'(NUM_SHIFTS - 1)) begin
                    w_state_next = LATCH;
                end
            end
            LATCH: begin
                w_bcd_next   = r_shift[19:8];
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;

endmodule

// File: rtl/count_display_driver.sv
// Drives a 4-digit common-anode multiplexed display from the 8-bit count.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the hundreds and tens digits.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int unsigned REFRESH_MAX = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    output logic [BCD_W-1:0]   bcd,
    output logic               busy,
    output logic [SEG_W-1:0]   seg,
    output logic [AN_W-1:0]    an,
    output logic               dp
);

    localparam int unsigned REFRESH_W = (REFRESH_MAX > 1) ? $clog2(REFRESH_MAX) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_MAX - 1);

    logic [BCD_W-1:0]     w_bcd;
    logic                 w_busy;
    bcd_t                 w_digits;
    logic [REFRESH_W-1:0] r_refresh_cnt;
    logic [REFRESH_W-1:0] w_refresh_next;
    digit_idx_t           r_digit_idx;
    digit_idx_t           w_digit_idx_next;
    logic [SEG_W-1:0]     r_seg;
    logic [SEG_W-1:0]     w_seg_next;
    logic [AN_W-1:0]      r_an;
    logic [AN_W-1:0]      w_an_next;
    logic                 w_blank_hundreds;
    logic                 w_blank_tens;

    bcd_converter u_bcd_converter (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .bcd   (w_bcd),
        .busy  (w_busy)
    );

    assign w_digits = bcd_t'(w_bcd);

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank_hundreds = (w_digits.hundreds == 4'd0);
    assign w_blank_tens     = (w_digits.hundreds == 4'd0) && (w_digits.tens == 4'd0);
`else
    assign w_blank_hundreds = 1'b0;
    assign w_blank_tens     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
            r_seg         <= SEG_BLANK;
            r_an          <= AN_OFF;
        end else begin
            r_refresh_cnt <= w_refresh_next;
            r_digit_idx   <= w_digit_idx_next;
            r_seg         <= w_seg_next;
            r_an          <= w_an_next;
        end
    end

    // Slot timer: the digit index steps once per REFRESH_MAX clocks.
    always_comb begin
        w_refresh_next   = r_refresh_cnt + REFRESH_W'(1);
        w_digit_idx_next = r_digit_idx;
        if (r_refresh_cnt == REFRESH_LAST) begin
            w_refresh_next   = '0;
            w_digit_idx_next = r_digit_idx + 2'd1;
        end
    end

    // seg and an are loaded from the upcoming index together so the digits never ghost.
    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = AN_OFF;
        case (w_digit_idx_next)
            2'd0: begin
                w_an_next  = 4'b1110;
                w_seg_next = seg_decode(w_digits.ones);
            end
            2'd1: begin
                w_an_next  = 4'b1101;
                w_seg_next = w_blank_tens ? SEG_BLANK : seg_decode(w_digits.tens);
            end
            2'd2: begin
                w_an_next  = 4'b1011;
                w_seg_next = w_blank_hundreds ? SEG_BLANK : seg_decode(w_digits.hundreds);
            end
            default: begin
                w_an_next  = AN_OFF;
                w_seg_next = SEG_BLANK;
            end
        endcase
    end

    assign bcd  = w_bcd;
    assign busy = w_busy;
    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver (REFRESH_MAX=4 and REFRESH_MAX=1 instances).
module tb_count_display_driver;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  value = 8'd0;

    logic [11:0] bcd4, bcd1;
    logic        busy4, busy1;
    logic [6:0]  seg4, seg1;
    logic [3:0]  an4, an1;
    logic        dp4, dp1;

    int checks = 0;
    int errors = 0;

    count_display_driver #(.REFRESH_MAX(4)) dut4 (
        .clk(clk), .reset(reset), .value(value),
        .bcd(bcd4), .busy(busy4), .seg(seg4), .an(an4), .dp(dp4)
    );

    count_display_driver #(.REFRESH_MAX(1)) dut1 (
        .clk(clk), .reset(reset), .value(value),
        .bcd(bcd1), .busy(busy1), .seg(seg1), .an(an1), .dp(dp1)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'h7F;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return S0;  4'd1: return S1;  4'd2: return S2;  4'd3: return S3;
            4'd4: return S4;  4'd5: return S5;  4'd6: return S6;  4'd7: return S7;
            4'd8: return S8;  4'd9: return S9;  default: return SB;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) * 256) + (((v / 10) % 10) * 16) + (v % 10));
    endfunction

    function automatic logic [3:0] exp_an(input int idx);
        case (idx)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] an_next(input logic [3:0] a);
        case (a)
            4'b1110: return 4'b1101;
            4'b1101: return 4'b1011;
            4'b1011: return 4'b1111;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b);
        logic blank_h, blank_t;
`ifdef LEADING_ZERO_BLANK_EN
        blank_h = (b[11:8] == 4'd0);
        blank_t = (b[11:8] == 4'd0) && (b[7:4] == 4'd0);
`else
        blank_h = 1'b0;
        blank_t = 1'b0;
`endif
        case (idx)
            0: return dec(b[3:0]);
            1: return blank_t ? SB : dec(b[7:4]);
            2: return blank_h ? SB : dec(b[11:8]);
            default: return SB;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: n counts clock edges since reset release; capture every 10th edge from the first.
    int          n = 0;
    int          cap = 0;
    logic [11:0] m_bcd = 12'h000;
    logic [6:0]  m_seg4 = SB, m_seg1 = SB;
    logic [3:0]  m_an4 = 4'hF, m_an1 = 4'hF;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; m_bcd = 12'h000;
            m_seg4 = SB; m_seg1 = SB; m_an4 = 4'hF; m_an1 = 4'hF;
        end else begin
            n++;
            m_an4  = exp_an((n / 4) % 4);
            m_seg4 = exp_seg((n / 4) % 4, m_bcd);
            m_an1  = exp_an(n % 4);
            m_seg1 = exp_seg(n % 4, m_bcd);
            if ((n - 1) % 10 == 0) cap = int'(value);
            if ((n - 1) % 10 == 9) m_bcd = to_bcd(cap);
        end
    end

    always @(posedge clk) begin
        #3;
        chk("bcd4", 32'(bcd4), 32'(m_bcd));
        chk("busy4", 32'(busy4), 32'((n % 10) != 0));
        chk("seg4", 32'(seg4), 32'(m_seg4));
        chk("an4", 32'(an4), 32'(m_an4));
        chk("dp4", 32'(dp4), 32'(1));
        chk("bcd1", 32'(bcd1), 32'(m_bcd));
        chk("seg1", 32'(seg1), 32'(m_seg1));
        chk("an1", 32'(an1), 32'(m_an1));
        chk("dp1", 32'(dp1), 32'(1));
    end

    typedef struct {
        logic [7:0]  v;
        logic [11:0] b;
        logic [6:0]  sh;
        logic [6:0]  st;
        logic [6:0]  so;
    } vec_t;

    vec_t tbl [7];

    task automatic wait_busy_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = busy4;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (busy4 && !prev) begin ok = 1'b1; break; end
            prev = busy4;
        end
        if (!ok) chk("busy_rise_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        bit          ok;
        int          first, bad, run;
        bit          seen;
        logic [3:0]  a, prev_a;

`ifdef LEADING_ZERO_BLANK_EN
        tbl[0] = '{8'd0,   12'h000, SB, SB, S0};
        tbl[1] = '{8'd7,   12'h007, SB, SB, S7};
        tbl[2] = '{8'd99,  12'h099, SB, S9, S9};
        tbl[3] = '{8'd10,  12'h010, SB, S1, S0};
`else
        tbl[0] = '{8'd0,   12'h000, S0, S0, S0};
        tbl[1] = '{8'd7,   12'h007, S0, S0, S7};
        tbl[2] = '{8'd99,  12'h099, S0, S9, S9};
        tbl[3] = '{8'd10,  12'h010, S0, S1, S0};
`endif
        tbl[4] = '{8'd100, 12'h100, S1, S0, S0};
        tbl[5] = '{8'd105, 12'h105, S1, S0, S5};
        tbl[6] = '{8'd255, 12'h255, S2, S5, S5};

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_seg", 32'(seg4), 32'(SB));
        chk("rst_an", 32'(an4), 32'(4'hF));
        chk("rst_bcd", 32'(bcd4), 32'(0));
        chk("rst_busy", 32'(busy4), 32'(0));
        reset = 1'b0;

        // Table: settle, then walk all four slots of the every-clock instance.
        for (int i = 0; i < 7; i++) begin
            value = tbl[i].v;
            repeat (20) @(negedge clk);
            chk("tbl_bcd", 32'(bcd4), 32'(tbl[i].b));
            for (int s = 0; s < 4; s++) begin
                case (an1)
                    4'b1110: chk("tbl_ones", 32'(seg1), 32'(tbl[i].so));
                    4'b1101: chk("tbl_tens", 32'(seg1), 32'(tbl[i].st));
                    4'b1011: chk("tbl_hund", 32'(seg1), 32'(tbl[i].sh));
                    4'b1111: chk("tbl_blank", 32'(seg1), 32'(SB));
                    default: chk("tbl_an_onehot", 32'(an1), 32'(4'b1110));
                endcase
                @(negedge clk);
            end
        end

        // Slot timing with REFRESH_MAX=4 while 255 is held.
        seen = 1'b0; run = 0; prev_a = an4;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            a = an4;
            if (a != prev_a) begin
                if (seen) chk("an4_run", 32'(run), 32'(4));
                chk("an4_next", 32'(a), 32'(an_next(prev_a)));
                seen = 1'b1; run = 1;
            end else begin
                run++;
            end
            prev_a = a;
        end

        // 99 -> 100 three clocks into SHIFT: only 099 or 100 may appear, 100 after 16 edges.
        value = 8'd99;
        repeat (20) @(negedge clk);
        wait_busy_rise(ok);
        repeat (3) @(negedge clk);
        value = 8'd100;
        first = -1; bad = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bcd4 != 12'h099 && bcd4 != 12'h100) bad++;
            if (bcd4 == 12'h100 && first < 0) first = k;
        end
        chk("chg_glitch", 32'(bad), 32'(0));
        chk("chg_latency", 32'(first), 32'(16));

        // Asynchronous reset mid-SHIFT, then first update 10 clocks after release.
        value = 8'd255;
        repeat (20) @(negedge clk);
        wait_busy_rise(ok);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_seg", 32'(seg4), 32'(SB));
        chk("mid_rst_an", 32'(an4), 32'(4'hF));
        chk("mid_rst_bcd", 32'(bcd4), 32'(0));
        chk("mid_rst_busy", 32'(busy4), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #3;
            if (bcd4 == 12'h255) begin first = k; break; end
        end
        chk("rst_relatch", 32'(first), 32'(10));

        // Full sweep.
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            value = 8'(v);
            repeat (20) @(negedge clk);
            chk("sweep_bcd", 32'(bcd4), 32'(to_bcd(v)));
        end

        // Random values with random hold times against the cycle model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            value = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
